// File: rtl/sifre_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : sifre_pkg
//  Purpose  : Shared types and helpers for the password-verification stage.
//  Revision : 1.0  initial release
// ============================================================================
package sifre_pkg;

  // Controller states
  typedef enum logic [2:0] {
    BEKLE       = 3'd0,
    GIRIS       = 3'd1,
    KARSILASTIR = 3'd2,
    ACIK        = 3'd3,
    KILITLI     = 3'd4
  } durum_t;

  // Bits per keypad digit
  localparam int HANE_GENISLIK = 4;

  // Width of the shared down-counter. It is loaded with (duration - 1), so
  // $clog2 of the longest duration is enough to hold the largest load value.
  function automatic int sayac_genislik(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage
`default_nettype wire

// File: rtl/sure_sayaci.sv
`default_nettype none
// ============================================================================
//  Module   : sure_sayaci
//  Purpose  : Loadable down-counter. A load of L makes 'bitti' rise after L
//             further clock edges, so loading (duration - 1) on state entry
//             gives a state that lasts exactly 'duration' cycles.
//  Revision : 1.0  initial release
// ============================================================================
module sure_sayaci #(
  parameter int GENISLIK = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                yukle,
  input  logic [GENISLIK-1:0] yukle_deger,
  output logic                bitti
);

  logic [GENISLIK-1:0] sayac;
  logic                aktif;

  // Count down after a load; stop (and drop 'aktif') once zero has been seen
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sayac <= '0;
      aktif <= 1'b0;
    end else if (yukle) begin
      sayac <= yukle_deger;
      aktif <= 1'b1;
    end else if (aktif) begin
      if (sayac == '0) begin
        aktif <= 1'b0;
      end else begin
        sayac <= sayac - 1'b1;
      end
    end
  end

  // Single-cycle done pulse while the count sits at zero
  always_comb begin
    bitti = aktif && (sayac == '0);
  end

endmodule
`default_nettype wire

// File: rtl/sifre_kontrol.sv
`default_nettype none
// ============================================================================
//  Module   : sifre_kontrol
//  Purpose  : Collects keypad digits into a code, compares it with the stored
//             code, opens the door for a fixed time on a match and raises a
//             timed alarm/lockout after repeated wrong codes.
//  Revision : 1.0  initial release
// ============================================================================
module sifre_kontrol
  import sifre_pkg::*;
#(
  parameter int HANE_SAYISI = 4,
  parameter int ACIK_SURE   = 50_000_000,
  parameter int MAX_HATA    = 3,
  parameter int KILIT_SURE  = 500_000_000,
  parameter int ZAMAN_ASIMI = 250_000_000
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic [HANE_GENISLIK-1:0]               sayi_girisi,
  input  logic                                   sifre_butonu,
  input  logic                                   iptal,
  input  logic [HANE_GENISLIK*HANE_SAYISI-1:0]   sifre_degeri,
  output logic                                   kapi_ac,
  output logic                                   alarm,
  output logic [$clog2(HANE_SAYISI+1)-1:0]       hane_sayaci,
  output logic [$clog2(MAX_HATA+1)-1:0]          hata_sayisi
);

  localparam int SAYAC_W = sayac_genislik(ACIK_SURE, KILIT_SURE, ZAMAN_ASIMI);
  localparam int HANE_W  = $clog2(HANE_SAYISI + 1);
  localparam int HATA_W  = $clog2(MAX_HATA + 1);

  localparam logic [SAYAC_W-1:0] ACIK_YUK  = SAYAC_W'(ACIK_SURE - 1);
  localparam logic [SAYAC_W-1:0] KILIT_YUK = SAYAC_W'(KILIT_SURE - 1);
  localparam logic [SAYAC_W-1:0] ZAMAN_YUK = SAYAC_W'(ZAMAN_ASIMI - 1);

  durum_t                               durum;
  logic [HANE_GENISLIK*HANE_SAYISI-1:0] tampon;

  logic               eslesme;      // entered code equals stored code
  logic               dolu;         // all digits collected
  logic               kilit_gerekli;// this mismatch reaches MAX_HATA
  logic               hane_yaz;     // accept the current digit strobe
  logic               sure_bitti;
  logic               yukle;
  logic [SAYAC_W-1:0] yukle_deger;

  // One timer serves all timed states; they are mutually exclusive
  sure_sayaci #(
    .GENISLIK (SAYAC_W)
  ) u_sure (
    .clk         (clk),
    .rst_n       (rst_n),
    .yukle       (yukle),
    .yukle_deger (yukle_deger),
    .bitti       (sure_bitti)
  );

  // Decision terms shared by the timer-load logic and the FSM
  always_comb begin
    eslesme       = (tampon == sifre_degeri);
    dolu          = (int'(hane_sayaci) == HANE_SAYISI);
    kilit_gerekli = (int'(hata_sayisi) + 1 >= MAX_HATA);
    hane_yaz      = 1'b0;
    yukle         = 1'b0;
    yukle_deger   = '0;
    case (durum)
      BEKLE: begin
        // cancel in the same cycle discards the digit
        if (sifre_butonu && !iptal) begin
          hane_yaz    = 1'b1;
          yukle       = 1'b1;
          yukle_deger = ZAMAN_YUK;
        end
      end
      GIRIS: begin
        // priority: cancel, full buffer, idle timeout, then the new digit
        if (sifre_butonu && !iptal && !dolu && !sure_bitti) begin
          hane_yaz    = 1'b1;
          yukle       = 1'b1;
          yukle_deger = ZAMAN_YUK;
        end
      end
      KARSILASTIR: begin
        if (eslesme) begin
          yukle       = 1'b1;
          yukle_deger = ACIK_YUK;
        end else if (kilit_gerekli) begin
          yukle       = 1'b1;
          yukle_deger = KILIT_YUK;
        end
      end
      default: begin
      end
    endcase
  end

  // Main controller: digit buffer, counters, state and registered outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      durum       <= BEKLE;
      tampon      <= '0;
      hane_sayaci <= '0;
      hata_sayisi <= '0;
      kapi_ac     <= 1'b0;
      alarm       <= 1'b0;
    end else begin
      if (hane_yaz) begin
        for (int i = 0; i < HANE_SAYISI; i++) begin
          if (int'(hane_sayaci) == i) begin
            tampon[i*HANE_GENISLIK +: HANE_GENISLIK] <= sayi_girisi;
          end
        end
      end

      case (durum)
        BEKLE: begin
          if (hane_yaz) begin
            hane_sayaci <= HANE_W'(1);
            durum       <= (HANE_SAYISI == 1) ? KARSILASTIR : GIRIS;
          end
        end
        GIRIS: begin
          if (iptal) begin
            hane_sayaci <= '0;
            durum       <= BEKLE;
          end else if (dolu) begin
            durum       <= KARSILASTIR;
          end else if (sure_bitti) begin
            hane_sayaci <= '0;
            durum       <= BEKLE;
          end else if (hane_yaz) begin
            hane_sayaci <= hane_sayaci + 1'b1;
          end
        end
        KARSILASTIR: begin
          hane_sayaci <= '0;
          if (eslesme) begin
            hata_sayisi <= '0;
            kapi_ac     <= 1'b1;
            durum       <= ACIK;
          end else if (kilit_gerekli) begin
            hata_sayisi <= HATA_W'(MAX_HATA);
            alarm       <= 1'b1;
            durum       <= KILITLI;
          end else begin
            hata_sayisi <= hata_sayisi + 1'b1;
            durum       <= BEKLE;
          end
        end
        ACIK: begin
          if (iptal || sure_bitti) begin
            kapi_ac <= 1'b0;
            durum   <= BEKLE;
          end
        end
        KILITLI: begin
          if (sure_bitti) begin
            alarm       <= 1'b0;
            hata_sayisi <= '0;
            durum       <= BEKLE;
          end
        end
        default: begin
          kapi_ac <= 1'b0;
          alarm   <= 1'b0;
          durum   <= BEKLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sifre_kontrol.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sifre_kontrol
//  Purpose  : Self-checking bench for sifre_kontrol: directed vector table,
//             hand-written corner sequences and a randomized run compared
//             against a queue-based behavioural model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_sifre_kontrol;

  localparam int HS = 4;
  localparam int AS = 5;
  localparam int MH = 3;
  localparam int KS = 8;
  localparam int ZA = 10;
  localparam logic [15:0] KOD   = 16'h4321;
  localparam logic [15:0] YANLIS = 16'h5321;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  sayi_girisi = '0;
  logic        sifre_butonu = 1'b0;
  logic        iptal = 1'b0;
  logic [15:0] sifre_degeri = KOD;
  logic        kapi_ac;
  logic        alarm;
  logic [2:0]  hane_sayaci;
  logic [1:0]  hata_sayisi;

  sifre_kontrol #(
    .HANE_SAYISI (HS),
    .ACIK_SURE   (AS),
    .MAX_HATA    (MH),
    .KILIT_SURE  (KS),
    .ZAMAN_ASIMI (ZA)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .sayi_girisi  (sayi_girisi),
    .sifre_butonu (sifre_butonu),
    .iptal        (iptal),
    .sifre_degeri (sifre_degeri),
    .kapi_ac      (kapi_ac),
    .alarm        (alarm),
    .hane_sayaci  (hane_sayaci),
    .hata_sayisi  (hata_sayisi)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic       b;
    logic       c;
    logic       r;
    logic [3:0] d;
    logic       k;
    logic       a;
    logic [2:0] hs;
    logic [1:0] hh;
  } vec_t;

  vec_t tbl[$];

  // Behavioural model: digits in a queue, remaining-cycle counters
  int m_q[$];
  int m_cmp, m_door, m_lock, m_idle, m_hata;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic chk4(input string nm, input int k, input int a, input int hs, input int hh);
    chk({nm, ".kapi_ac"}, 32'(kapi_ac), k);
    chk({nm, ".alarm"}, 32'(alarm), a);
    chk({nm, ".hane_sayaci"}, 32'(hane_sayaci), hs);
    chk({nm, ".hata_sayisi"}, 32'(hata_sayisi), hh);
  endtask

  // Drive one cycle of inputs, then sample 1 time unit after the edge
  task automatic step(input logic b, input logic c, input logic [3:0] d, input logic r);
    sifre_butonu = b;
    iptal        = c;
    sayi_girisi  = d;
    rst_n        = r;
    @(posedge clk);
    #1;
    sifre_butonu = 1'b0;
    iptal        = 1'b0;
    rst_n        = 1'b1;
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 4'd0, 1'b1);
  endtask

  task automatic do_reset();
    step(1'b0, 1'b0, 4'd0, 1'b0);
  endtask

  // Four consecutive strobes then two idle cycles: result visible afterwards
  task automatic enter_code(input logic [15:0] code);
    for (int i = 0; i < HS; i++) step(1'b1, 1'b0, code[i*4 +: 4], 1'b1);
    idle();
    idle();
  endtask

  task automatic tv(input logic b, input logic c, input logic r, input logic [3:0] d,
                    input logic k, input logic a, input logic [2:0] hs, input logic [1:0] hh);
    vec_t v;
    v.b = b; v.c = c; v.r = r; v.d = d; v.k = k; v.a = a; v.hs = hs; v.hh = hh;
    tbl.push_back(v);
  endtask

  function automatic int kod_hane(input int i);
    return int'((KOD >> (4 * i)) & 16'hF);
  endfunction

  task automatic model_step(input logic b, input logic c, input logic [3:0] d, input logic r);
    bit ok;
    if (!r) begin
      m_q.delete();
      m_cmp = 0; m_door = 0; m_lock = 0; m_idle = 0; m_hata = 0;
    end else if (m_door > 0) begin
      m_door = c ? 0 : m_door - 1;
    end else if (m_lock > 0) begin
      m_lock--;
      if (m_lock == 0) m_hata = 0;
    end else if (m_cmp != 0) begin
      m_cmp = 0;
      ok = 1'b1;
      for (int i = 0; i < HS; i++) if (m_q[i] != kod_hane(i)) ok = 1'b0;
      m_q.delete();
      if (ok) begin
        m_hata = 0;
        m_door = AS;
      end else if (m_hata + 1 >= MH) begin
        m_hata = MH;
        m_lock = KS;
      end else begin
        m_hata++;
      end
    end else if (m_q.size() == HS) begin
      if (c) m_q.delete();
      else   m_cmp = 1;
    end else if (m_q.size() > 0) begin
      m_idle++;
      if (c) m_q.delete();
      else if (m_idle >= ZA) m_q.delete();
      else if (b) begin
        m_q.push_back(int'(d));
        m_idle = 0;
      end
    end else if (b && !c) begin
      m_q.push_back(int'(d));
      m_idle = 0;
    end
  endtask

  initial begin
    int n;
    int dens;
    logic rb, rc, rr;
    logic [3:0] rd;

    // ---------------- directed table ----------------
    tv(0,0,0,0, 0,0,0,0);                       // reset
    tv(1,0,1,1, 0,0,1,0);
    tv(1,0,1,2, 0,0,2,0);
    tv(1,0,1,3, 0,0,3,0);
    tv(1,0,1,4, 0,0,4,0);
    tv(0,0,1,0, 0,0,4,0);                       // compare cycle
    tv(0,0,1,0, 1,0,0,0);                       // door open, cycle 1
    tv(1,0,1,1, 1,0,0,0);                       // strobe ignored while open
    tv(0,0,1,0, 1,0,0,0);
    tv(0,0,1,0, 1,0,0,0);
    tv(0,0,1,0, 1,0,0,0);                       // cycle 5
    tv(0,0,1,0, 0,0,0,0);                       // closed
    tv(1,0,1,1, 0,0,1,0);                       // wrong code 1,2,3,5
    tv(1,0,1,2, 0,0,2,0);
    tv(1,0,1,3, 0,0,3,0);
    tv(1,0,1,5, 0,0,4,0);
    tv(0,0,1,0, 0,0,4,0);
    tv(0,0,1,0, 0,0,0,1);
    tv(1,0,1,1, 0,0,1,1);                       // correct code clears failures
    tv(1,0,1,2, 0,0,2,1);
    tv(1,0,1,3, 0,0,3,1);
    tv(1,0,1,4, 0,0,4,1);
    tv(0,0,1,0, 0,0,4,1);
    tv(0,0,1,0, 1,0,0,0);

    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].b, tbl[i].c, tbl[i].d, tbl[i].r);
      chk4($sformatf("tbl[%0d]", i), int'(tbl[i].k), int'(tbl[i].a),
           int'(tbl[i].hs), int'(tbl[i].hh));
    end

    // ---------------- lockout ----------------
    do_reset();
    enter_code(YANLIS);
    chk("lock.hata1", 32'(hata_sayisi), 1);
    enter_code(YANLIS);
    chk("lock.hata2", 32'(hata_sayisi), 2);
    enter_code(YANLIS);
    chk4("lock.start", 0, 1, 0, 3);
    enter_code(KOD);                            // ignored during lockout
    chk4("lock.code_ignored", 0, 1, 0, 3);
    n = 7;
    for (int g = 0; g < 20; g++) begin
      idle();
      if (alarm) n++;
      else break;
    end
    chk("lock.length", n, KS);
    chk4("lock.end", 0, 0, 0, 0);

    // ---------------- timeout ----------------
    do_reset();
    enter_code(YANLIS);
    step(1'b1, 1'b0, 4'd1, 1'b1);
    step(1'b1, 1'b0, 4'd2, 1'b1);
    chk4("tmo.two_digits", 0, 0, 2, 1);
    repeat (ZA - 1) idle();
    chk4("tmo.before", 0, 0, 2, 1);
    idle();
    chk4("tmo.expired", 0, 0, 0, 1);
    enter_code(KOD);
    chk4("tmo.then_open", 1, 0, 0, 0);

    // ---------------- cancel / collision ----------------
    do_reset();
    step(1'b1, 1'b0, 4'd1, 1'b1);
    step(1'b1, 1'b0, 4'd2, 1'b1);
    step(1'b1, 1'b1, 4'd3, 1'b1);               // cancel wins over 3rd digit
    chk4("cancel.collide", 0, 0, 0, 0);
    enter_code(KOD);
    chk4("cancel.open", 1, 0, 0, 0);
    idle();
    chk("cancel.open2", 32'(kapi_ac), 1);
    step(1'b0, 1'b1, 4'd0, 1'b1);
    chk4("cancel.door_closed", 0, 0, 0, 0);

    // ---------------- reset mid-operation ----------------
    enter_code(YANLIS);
    enter_code(YANLIS);
    enter_code(YANLIS);
    chk("rst.in_lock", 32'(alarm), 1);
    do_reset();
    chk4("rst.lock_cleared", 0, 0, 0, 0);
    enter_code(KOD);
    chk("rst.open_after", 32'(kapi_ac), 1);
    idle();
    do_reset();
    chk4("rst.door_cleared", 0, 0, 0, 0);
    enter_code(KOD);
    chk("rst.open_again", 32'(kapi_ac), 1);

    // ---------------- randomized vs model ----------------
    do_reset();
    model_step(1'b0, 1'b0, 4'd0, 1'b0);
    dens = 1;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (cyc % 50 == 0) begin
        case ($urandom_range(0, 3))
          0: dens = 0;
          1: dens = 1;
          2: dens = 4;
          default: dens = 14;
        endcase
      end
      rb = ($urandom_range(0, dens) == 0);
      rc = ($urandom_range(0, 39) == 0);
      rr = ($urandom_range(0, 599) != 0);
      if ($urandom_range(0, 9) < 8 && m_q.size() < HS)
        rd = 4'(kod_hane(m_q.size()));
      else
        rd = 4'($urandom_range(0, 15));
      step(rb, rc, rd, rr);
      model_step(rb, rc, rd, rr);
      chk4($sformatf("rnd[%0d]", cyc), (m_door > 0) ? 1 : 0, (m_lock > 0) ? 1 : 0,
           m_q.size(), m_hata);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
